// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath; Moore outputs from state_q.
// 3-5 cycles per instruction; FETCH/MEMRD/MEMWR hold while mem_ready is low.
module multicycle_control #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      aluop,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic            pc_en,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            instr_done,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;
  logic   funct_legal;
  logic [2:0] funct_aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    funct_legal = 1'b1;
    funct_aluop = 3'b010;
    case (funct)
      6'b100000: funct_aluop = 3'b010;
      6'b100010: funct_aluop = 3'b110;
      6'b100100: funct_aluop = 3'b000;
      6'b100101: funct_aluop = 3'b001;
      6'b101010: funct_aluop = 3'b111;
      default:   funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    aluop      = 3'b010;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else if (opcode == OP_LW) state_d = S_MEMRD;
        else state_d = S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = funct_aluop;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = funct_legal;
        illegal_op = ~funct_legal;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = 3'b100;
        pc_source  = 2'b01;
        pc_en      = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // state_q is already FETCH under reset; this also silences the FETCH enables.
    if (!rst_n) begin
      aluop      = 3'b010;
      alu_src_b  = 2'b00;
      pc_en      = 1'b0;
      mem_read   = 1'b0;
      ir_write   = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction stream
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic [2:0] aluop;
  logic alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, instr_done, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, done, ill;
  } out_t;

  out_t exp_q[$];
  logic mr_q[$];
  logic zr_q[$];

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .aluop(aluop), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t observed();
    out_t o;
    o = {state, aluop, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
         mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};
    return o;
  endfunction

  function automatic out_t base(input logic [3:0] s);
    out_t o;
    o = '0;
    o.st = s;
    o.aluop = 3'b010;
    return o;
  endfunction

  task automatic push(input out_t o, input logic mr, input logic zr);
    exp_q.push_back(o);
    mr_q.push_back(mr);
    zr_q.push_back(zr);
  endtask

  // Instruction-level model: expected per-cycle outputs for one instruction.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw, output int lat);
    out_t o;
    logic legal;
    logic [2:0] fop;
    legal = 1'b1;
    case (fn)
      6'b100000: fop = 3'b010;
      6'b100010: fop = 3'b110;
      6'b100100: fop = 3'b000;
      6'b100101: fop = 3'b001;
      6'b101010: fop = 3'b111;
      default: begin fop = 3'b010; legal = 1'b0; end
    endcase
    for (int i = 0; i < fw; i++) begin
      o = base(0); o.mrd = 1; o.srcb = 2'b01;
      push(o, 1'b0, 1'($urandom));
    end
    o = base(0); o.mrd = 1; o.srcb = 2'b01; o.irw = 1; o.pcen = 1;
    push(o, 1'b1, 1'($urandom));
    o = base(1); o.srcb = 2'b11;
    case (op)
      6'b100011, 6'b101011: begin
        push(o, 1'($urandom), 1'($urandom));
        o = base(2); o.srca = 1; o.srcb = 2'b10;
        push(o, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= mw; i++) begin
          if (op == 6'b100011) begin
            o = base(3); o.mrd = 1; o.iord = 1;
          end else begin
            o = base(5); o.mwr = 1; o.iord = 1; o.done = (i == mw);
          end
          push(o, i == mw, 1'($urandom));
        end
        if (op == 6'b100011) begin
          o = base(4); o.rw = 1; o.m2r = 1; o.done = 1;
          push(o, 1'($urandom), 1'($urandom));
          lat = 5 + fw + mw;
        end else lat = 4 + fw + mw;
      end
      6'b000000: begin
        push(o, 1'($urandom), 1'($urandom));
        o = base(6); o.srca = 1; o.aluop = fop;
        push(o, 1'($urandom), 1'($urandom));
        o = base(7); o.rdst = 1; o.rw = legal; o.ill = !legal; o.done = 1;
        push(o, 1'($urandom), 1'($urandom));
        lat = 4 + fw;
      end
      6'b000100, 6'b000101: begin
        push(o, 1'($urandom), 1'($urandom));
        o = base(8); o.srca = 1; o.aluop = 3'b100; o.pcsrc = 2'b01; o.done = 1;
        o.pcen = (op == 6'b000100) ? z : !z;
        push(o, 1'($urandom), z);
        lat = 3 + fw;
      end
      6'b000010: begin
        push(o, 1'($urandom), 1'($urandom));
        o = base(9); o.pcsrc = 2'b10; o.pcen = 1; o.done = 1;
        push(o, 1'($urandom), 1'($urandom));
        lat = 3 + fw;
      end
      6'b001000: begin
        push(o, 1'($urandom), 1'($urandom));
        o = base(10); o.srca = 1; o.srcb = 2'b10;
        push(o, 1'($urandom), 1'($urandom));
        o = base(11); o.rw = 1; o.done = 1;
        push(o, 1'($urandom), 1'($urandom));
        lat = 4 + fw;
      end
      default: begin
        o.ill = 1; o.done = 1;
        push(o, 1'($urandom), 1'($urandom));
        lat = 2 + fw;
      end
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    int lat;
    int done_at;
    out_t obs;
    exp_q.delete(); mr_q.delete(); zr_q.delete();
    model_instr(op, fn, z, fw, mw, lat);
    opcode = op;
    funct = fn;
    done_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = mr_q[i];
      zero = zr_q[i];
      #2;
      obs = observed();
      total++;
      if (obs !== exp_q[i])
        begin bad++; $display("FAIL cycle op=%b fn=%b idx=%0d got=%h want=%h", op, fn, i, obs, exp_q[i]); end
      total++;
      if (mem_write && reg_write)
        begin bad++; $display("FAIL wr_excl op=%b idx=%0d got=both want=not both", op, i); end
      if (instr_done && done_at < 0) done_at = i + 1;
      @(posedge clk); #1;
    end
    total++;
    if (done_at !== lat)
      begin bad++; $display("FAIL latency op=%b got=%0d want=%0d", op, done_at, lat); end
  endtask

  task automatic test_reset();
    out_t obs;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    opcode = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      obs = observed();
      total++;
      if (obs !== base(0))
        begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, base(0)); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype_sub();   run_instr(6'b000000, 6'b100010, 1'b0, 0, 0); endtask
  task automatic test_lw_wait();     run_instr(6'b100011, 6'b000000, 1'b0, 0, 2); endtask
  task automatic test_fetch_stall(); run_instr(6'b001000, 6'b000000, 1'b0, 4, 0); endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'b100000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 1);
  endtask

  task automatic test_async_reset();
    opcode = 6'b101011; funct = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #2;
    total++;
    if (state !== 4'd5 || mem_write !== 1'b1)
      begin bad++; $display("FAIL pre_abort got st=%0d mw=%b want st=5 mw=1", state, mem_write); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0)
      begin bad++; $display("FAIL async_abort got st=%0d mw=%b rw=%b want 0/0/0", state, mem_write, reg_write); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    total++;
    if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b0)
      begin bad++; $display("FAIL post_reset got st=%0d mrd=%b irw=%b want 0/1/0", state, mem_read, ir_write); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b000101, 6'b000010, 6'b001000, 6'b110011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_fetch_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch/decode/execute/memory/writeback and drives the ALU operation code plus all datapath enables and mux selects. It consumes the ALU `zero` flag to resolve branches and the memory `mem_ready` handshake to stall on memory accesses.

Parameters:
- OP_W, 6, opcode and funct field width.
- ST_W, 4, state register width (12 states used).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from IR; stable from DECODE until instr_done.
- funct  in  6  instr[5:0] from IR; same stability.
- zero  in  1  ALU compare flag (1 when a==b under aluop 100).
- mem_ready  in  1  memory access complete this cycle.
- aluop  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 compare.
- alu_src_a  out  1  0=PC, 1=A reg.
- alu_src_b  out  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_en  out  1  PC write enable (unconditional or branch-resolved).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode/funct.
- state  out  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset (rst_n low, async): state=FETCH. While reset is held, every enable (pc_en, ir_write, mem_read, mem_write, reg_write, instr_done, illegal_op) is 0, all selects are 0, aluop=010.
- Reset mid-instruction aborts the instruction; no write enables assert until rst_n is high.
- Outputs are combinational from the state register (Moore), except pc_en in BRANCH and handshake-gated enables. Unlisted outputs are 0; aluop defaults to 010.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=010, pc_source=00. ir_write=pc_en=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, aluop=010 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> illegal_op=1, instr_done=1, next FETCH.
- MEMADR / ADDIEX: alu_src_a=1, alu_src_b=10, aluop=010. MEMADR -> MEMRD (lw) or MEMWR (sw); ADDIEX -> ADDIWB.
- MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEMWR: mem_write=1, iord=1; hold until mem_ready=1. On mem_ready: instr_done=1 -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. aluop by funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010
  -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0. reg_write=1 only for a legal funct; otherwise reg_write=0 and illegal_op=1. instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=100, pc_source=01. pc_en=zero for beq, pc_en=~zero for bne. instr_done=1 -> FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1 -> FETCH.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH.
- Latency with zero wait states, in cycles: beq/bne/j 3; R-type/sw/addi 4; lw 5. Each mem_ready=0 cycle adds exactly one cycle.
- mem_write and reg_write are never both 1 in the same cycle.
- Undefined state encodings (12-15) -> FETCH on the next edge with no enables asserted.

Test Plan:
- Reset low for 3 cycles, release with mem_ready=1 and opcode=000000, funct=100010 -> states 0,1,6,7. In EXEC aluop=110; ALUWB reg_write=1, reg_dst=1, instr_done=1.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, total 7 cycles. MEMWB mem_to_reg=1, reg_write=1.
- beq with zero=1 -> BRANCH pc_en=1, pc_source=01. bne with zero=1 -> pc_en=0. bne with zero=0 -> pc_en=1. Each takes 3 cycles.
- opcode=111111 -> DECODE asserts illegal_op=1 and instr_done=1, then FETCH with no reg_write or mem_write. R-type funct=000111 -> ALUWB reg_write=0, illegal_op=1.
- Assert rst_n low asynchronously mid-MEMWR -> mem_write drops immediately and state=0. After release, the first cycle is a FETCH with mem_read=1.
- FETCH with mem_ready=0 for 4 cycles -> ir_write=pc_en=0 and state held at 0. On mem_ready=1, ir_write=pc_en=1 for exactly one cycle.
